// File: rtl/tstate_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : tstate_seq_if
//  Brief    : Decoder/bus-side signal bundle of the T-state sequencer.
//             The slave modport is the sequencer. The master modport is the
//             decoder and bus-interface side that drives it.
//  Revision : 1.0 - initial release
// ============================================================================
interface tstate_seq_if #(
    parameter int WCW = 4
);
    // decoder / bus inputs to the sequencer
    logic           ready;
    logic           bus_idle;
    logic           hold;
    logic           halt_req;
    logic           wake;
    logic [2:0]     cyc_len;
    logic           last_mc;
    // sequencer outputs
    logic [3:0]     tstate;
    logic           ale;
    logic           mc_done;
    logic           hlda;
    logic           in_wait;
    logic           halted;
    logic           wait_timeout;
    logic [WCW-1:0] wait_cnt;
    logic [2:0]     mc_index;

    modport slave (
        input  ready, bus_idle, hold, halt_req, wake, cyc_len, last_mc,
        output tstate, ale, mc_done, hlda, in_wait, halted, wait_timeout,
               wait_cnt, mc_index
    );

    modport master (
        output ready, bus_idle, hold, halt_req, wake, cyc_len, last_mc,
        input  tstate, ale, mc_done, hlda, in_wait, halted, wait_timeout,
               wait_cnt, mc_index
    );
endinterface
`default_nettype wire

// File: rtl/tstate_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tstate_seq
//  Brief    : 8085-style machine-cycle T-state sequencer. It supports
//             machine cycles of 3 to 6 T-states, counted auto-wait, a wait
//             timeout, a selectable HOLD acceptance mode, a return to HALT
//             after HOLD, and a machine-cycle index.
//  Revision : 1.0 - initial release
// ============================================================================
module tstate_seq #(
    parameter int AUTO_WAIT   = 0,
    parameter int WAIT_MAX    = 0,
    parameter int WCW         = 4,
    parameter int HOLD_ANY_MC = 0
) (
    input  wire           clock,
    input  wire           reset,
    tstate_seq_if.slave   bus
);

    // State codes double as the externally visible tstate value
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T1    = 4'd1;
    localparam logic [3:0] S_T2    = 4'd2;
    localparam logic [3:0] S_T3    = 4'd3;
    localparam logic [3:0] S_T4    = 4'd4;
    localparam logic [3:0] S_T5    = 4'd5;
    localparam logic [3:0] S_T6    = 4'd6;
    localparam logic [3:0] S_HOLD  = 4'd7;
    localparam logic [3:0] S_HALT  = 4'd9;
    localparam logic [3:0] S_TW    = 4'd10;

    localparam logic [WCW-1:0] c_auto_wait = AUTO_WAIT[WCW-1:0];
    localparam logic [WCW-1:0] c_wait_max  = WAIT_MAX[WCW-1:0];
    localparam logic [WCW-1:0] c_cnt_ones  = '1;
    localparam bit             c_hold_any  = (HOLD_ANY_MC != 0);
    localparam bit             c_has_tmo   = (WAIT_MAX != 0);

    logic [3:0]     r_state;
    logic [2:0]     r_len;
    logic [WCW-1:0] r_wait_cnt;
    logic [2:0]     r_mc_index;
    logic           r_halt_pend;

    logic [2:0]     w_len_in;
    logic           w_wait_need;
    logic           w_timeout;
    logic           w_final;
    logic           w_hold_ok;
    logic [WCW-1:0] w_cnt_inc;

    // Map the decoder's cycle length onto the supported range of 3..6
    always_comb begin
        w_len_in = bus.cyc_len;
        if (bus.cyc_len < 3'd3)
            w_len_in = 3'd3;
        else if (bus.cyc_len == 3'd7)
            w_len_in = 3'd6;
    end

    // A wait is needed while the bus is not ready or auto-wait states remain.
    // The wait counter saturates instead of wrapping.
    assign w_wait_need = !bus.ready || (r_wait_cnt < c_auto_wait);
    assign w_cnt_inc   = (r_wait_cnt == c_cnt_ones) ? r_wait_cnt : r_wait_cnt + 1'b1;
    assign w_timeout   = c_has_tmo && (r_state == S_TW) && (r_wait_cnt == c_wait_max);
    assign w_hold_ok   = bus.hold && (c_hold_any || bus.last_mc);

    // The current T-state is the last one when it matches the captured length
    assign w_final = ((r_state == S_T3) && (r_len == 3'd3)) ||
                     ((r_state == S_T4) && (r_len == 3'd4)) ||
                     ((r_state == S_T5) && (r_len == 3'd5)) ||
                      (r_state == S_T6);

    // Sequencer state, cycle length, wait counter, machine-cycle index and halt-return flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_RESET;
            r_len       <= 3'd4;
            r_wait_cnt  <= '0;
            r_mc_index  <= 3'd0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T1;
                S_T1: begin
                    r_wait_cnt <= '0;
                    if (bus.halt_req) begin
                        r_state    <= S_HALT;
                        r_mc_index <= 3'd0;
                    end else begin
                        r_state <= S_T2;
                        r_len   <= w_len_in;
                    end
                end
                S_T2: begin
                    if (!bus.bus_idle && w_wait_need) begin
                        r_state    <= S_TW;
                        r_wait_cnt <= w_cnt_inc;
                    end else begin
                        r_state <= S_T3;
                    end
                end
                S_TW: begin
                    if (w_timeout) begin
                        r_state <= S_T3;
                    end else if (w_wait_need) begin
                        r_wait_cnt <= w_cnt_inc;
                    end else begin
                        r_state <= S_T3;
                    end
                end
                S_T3, S_T4, S_T5, S_T6: begin
                    if (w_final) begin
                        if (bus.last_mc)
                            r_mc_index <= 3'd0;
                        else if (r_mc_index != 3'd7)
                            r_mc_index <= r_mc_index + 3'd1;
                        r_state <= w_hold_ok ? S_HOLD : S_T1;
                    end else begin
                        r_state <= r_state + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (!bus.hold) begin
                        r_state     <= r_halt_pend ? S_HALT : S_T1;
                        r_halt_pend <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (bus.hold) begin
                        r_state     <= S_HOLD;
                        r_halt_pend <= 1'b1;
                    end else if (bus.wake) begin
                        r_state <= S_T1;
                    end
                end
                default: r_state <= S_RESET;
            endcase
        end
    end

    assign bus.tstate       = r_state;
    assign bus.ale          = (r_state == S_T1);
    assign bus.mc_done      = w_final;
    assign bus.hlda         = (r_state == S_HOLD);
    assign bus.in_wait      = (r_state == S_TW);
    assign bus.halted       = (r_state == S_HALT);
    assign bus.wait_timeout = w_timeout;
    assign bus.wait_cnt     = r_wait_cnt;
    assign bus.mc_index     = r_mc_index;

endmodule
`default_nettype wire

// File: tb/tb_tstate_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tstate_seq
//  Brief    : Self-checking bench for tstate_seq. One instance uses the
//             default parameters. A second instance uses AUTO_WAIT=2 and
//             WAIT_MAX=5 to cover auto-wait and the wait timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tstate_seq;

    typedef struct {
        string tag;
        int    sel;
        int    ts;
        int    md;
        int    wto;
        int    wc;
        int    mi;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       ready;
    logic       bus_idle;
    logic       hold;
    logic       halt_req;
    logic       wake;
    logic [2:0] cyc_len;
    logic       last_mc;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    tstate_seq_if #(.WCW(4)) if0 ();
    tstate_seq_if #(.WCW(4)) if1 ();

    assign if0.ready    = ready;
    assign if0.bus_idle = bus_idle;
    assign if0.hold     = hold;
    assign if0.halt_req = halt_req;
    assign if0.wake     = wake;
    assign if0.cyc_len  = cyc_len;
    assign if0.last_mc  = last_mc;
    assign if1.ready    = ready;
    assign if1.bus_idle = bus_idle;
    assign if1.hold     = hold;
    assign if1.halt_req = halt_req;
    assign if1.wake     = wake;
    assign if1.cyc_len  = cyc_len;
    assign if1.last_mc  = last_mc;

    tstate_seq #(.AUTO_WAIT(0), .WAIT_MAX(0), .WCW(4), .HOLD_ANY_MC(0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    tstate_seq #(.AUTO_WAIT(2), .WAIT_MAX(5), .WCW(4), .HOLD_ANY_MC(0)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push the expectation for the next edge, clock once, then pop and compare.
    // A value of -1 for wc or mi skips that field.
    task automatic step(input string tag, input int sel, input int ts, input int md,
                        input int wto, input int wc, input int mi);
        exp_t e;
        int   o_ts, o_ale, o_md, o_hlda, o_iw, o_hlt, o_wto, o_wc, o_mi;
        e.tag = tag; e.sel = sel; e.ts = ts; e.md = md; e.wto = wto; e.wc = wc; e.mi = mi;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (e.sel == 0) begin
            o_ts = int'(if0.tstate); o_ale = int'(if0.ale); o_md = int'(if0.mc_done);
            o_hlda = int'(if0.hlda); o_iw = int'(if0.in_wait); o_hlt = int'(if0.halted);
            o_wto = int'(if0.wait_timeout); o_wc = int'(if0.wait_cnt); o_mi = int'(if0.mc_index);
        end else begin
            o_ts = int'(if1.tstate); o_ale = int'(if1.ale); o_md = int'(if1.mc_done);
            o_hlda = int'(if1.hlda); o_iw = int'(if1.in_wait); o_hlt = int'(if1.halted);
            o_wto = int'(if1.wait_timeout); o_wc = int'(if1.wait_cnt); o_mi = int'(if1.mc_index);
        end
        check({e.tag, ".tstate"},  o_ts,   e.ts);
        check({e.tag, ".ale"},     o_ale,  (e.ts == 1)  ? 1 : 0);
        check({e.tag, ".mc_done"}, o_md,   e.md);
        check({e.tag, ".hlda"},    o_hlda, (e.ts == 7)  ? 1 : 0);
        check({e.tag, ".in_wait"}, o_iw,   (e.ts == 10) ? 1 : 0);
        check({e.tag, ".halted"},  o_hlt,  (e.ts == 9)  ? 1 : 0);
        check({e.tag, ".wait_to"}, o_wto,  e.wto);
        if (e.wc >= 0) check({e.tag, ".wait_cnt"}, o_wc, e.wc);
        if (e.mi >= 0) check({e.tag, ".mc_index"}, o_mi, e.mi);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; ready = 1'b1; bus_idle = 1'b0; hold = 1'b0;
        halt_req = 1'b0; wake = 1'b0; cyc_len = 3'd4; last_mc = 1'b1;

        // Reset state, then a basic 4-state cycle with no waits
        step("rst0", 0, 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("a_t1", 0, 1, 0, 0, -1, 0);
        step("a_t2", 0, 2, 0, 0, 0, 0);
        step("a_t3", 0, 3, 0, 0, 0, 0);
        step("a_t4", 0, 4, 1, 0, 0, 0);
        step("a_t1b", 0, 1, 0, 0, -1, 0);

        // A 6-state cycle with ready low for 3 clocks from T2
        cyc_len = 3'd6;
        step("b_t2", 0, 2, 0, 0, 0, 0);
        ready = 1'b0;
        step("b_tw1", 0, 10, 0, 0, 1, 0);
        step("b_tw2", 0, 10, 0, 0, 2, 0);
        step("b_tw3", 0, 10, 0, 0, 3, 0);
        ready = 1'b1;
        step("b_t3", 0, 3, 0, 0, 3, 0);
        step("b_t4", 0, 4, 0, 0, 3, 0);
        step("b_t5", 0, 5, 0, 0, 3, 0);
        step("b_t6", 0, 6, 1, 0, 3, 0);
        step("b_t1", 0, 1, 0, 0, -1, 0);

        // HOLD is taken only at the end of the last machine cycle.
        // cyc_len 1 maps to 3, and cyc_len changes after T1 are ignored.
        cyc_len = 3'd1; hold = 1'b1; last_mc = 1'b0;
        step("c_t2", 0, 2, 0, 0, 0, 0);
        cyc_len = 3'd6;
        step("c_t3", 0, 3, 1, 0, 0, 0);
        cyc_len = 3'd1;
        step("c_t1", 0, 1, 0, 0, -1, 1);
        last_mc = 1'b1;
        step("c_t2b", 0, 2, 0, 0, 0, 1);
        step("c_t3b", 0, 3, 1, 0, 0, 1);
        step("c_hold", 0, 7, 0, 0, 0, 0);
        step("c_hold2", 0, 7, 0, 0, 0, 0);
        hold = 1'b0;
        step("c_exit", 0, 1, 0, 0, -1, 0);

        // HALT, then a hold pulse that returns to HALT, then wake
        halt_req = 1'b1;
        step("d_halt", 0, 9, 0, 0, 0, 0);
        halt_req = 1'b0;
        step("d_halt2", 0, 9, 0, 0, 0, 0);
        hold = 1'b1;
        step("d_hold", 0, 7, 0, 0, 0, 0);
        hold = 1'b0;
        step("d_rehalt", 0, 9, 0, 0, 0, 0);
        wake = 1'b1;
        step("d_wake", 0, 1, 0, 0, -1, 0);
        wake = 1'b0;
        halt_req = 1'b1; hold = 1'b1;
        step("d_both_halt", 0, 9, 0, 0, 0, 0);
        step("d_both_hold", 0, 7, 0, 0, 0, 0);
        halt_req = 1'b0; hold = 1'b0;
        step("d_both_rehalt", 0, 9, 0, 0, 0, 0);
        wake = 1'b1;
        step("d_both_wake", 0, 1, 0, 0, -1, 0);
        wake = 1'b0;

        // Reset asserted in TW (with a nonzero mc_index), then in HOLD
        last_mc = 1'b0;
        step("e_t2", 0, 2, 0, 0, 0, 0);
        step("e_t3", 0, 3, 1, 0, 0, 0);
        step("e_t1", 0, 1, 0, 0, -1, 1);
        ready = 1'b0;
        step("e_t2b", 0, 2, 0, 0, 0, 1);
        step("e_tw", 0, 10, 0, 0, 1, 1);
        reset = 1'b1;
        step("e_rst_tw", 0, 0, 0, 0, 0, 0);
        reset = 1'b0; ready = 1'b1; last_mc = 1'b1;
        step("e_rel_tw", 0, 1, 0, 0, 0, 0);
        hold = 1'b1;
        step("e_t2c", 0, 2, 0, 0, 0, 0);
        step("e_t3c", 0, 3, 1, 0, 0, 0);
        step("e_hold", 0, 7, 0, 0, 0, 0);
        reset = 1'b1;
        step("e_rst_hold", 0, 0, 0, 0, 0, 0);
        reset = 1'b0; hold = 1'b0;
        step("e_rel_hold", 0, 1, 0, 0, 0, 0);

        // Auto-wait and timeout on the AUTO_WAIT=2, WAIT_MAX=5 instance
        reset = 1'b1; ready = 1'b0; cyc_len = 3'd1;
        step("f_rst", 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("f_t1", 1, 1, 0, 0, 0, 0);
        step("f_t2", 1, 2, 0, 0, 0, 0);
        step("f_tw1", 1, 10, 0, 0, 1, 0);
        step("f_tw2", 1, 10, 0, 0, 2, 0);
        step("f_tw3", 1, 10, 0, 0, 3, 0);
        step("f_tw4", 1, 10, 0, 0, 4, 0);
        step("f_tw5", 1, 10, 0, 1, 5, 0);
        step("f_t3", 1, 3, 1, 0, 5, 0);
        ready = 1'b1;
        step("f_t1b", 1, 1, 0, 0, -1, 0);
        step("f_t2b", 1, 2, 0, 0, 0, 0);
        step("f_aw1", 1, 10, 0, 0, 1, 0);
        step("f_aw2", 1, 10, 0, 0, 2, 0);
        step("f_t3b", 1, 3, 1, 0, 2, 0);
        bus_idle = 1'b1;
        step("f_t1c", 1, 1, 0, 0, -1, 0);
        step("f_t2c", 1, 2, 0, 0, 0, 0);
        step("f_t3c", 1, 3, 1, 0, 0, 0);
        step("f_t1d", 1, 1, 0, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
